// File: rtl/spi_ram_master_pkg.sv
// Shared encodings and sizing helpers for the SPI RAM host-side master.
package spi_ram_master_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_RD_WAIT,
    S_RD_CAP,
    S_GAP
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_master_sck_gen.sv
// SCK divider: CLK_DIV clk per half-period, one-clk rise/fall strobes.
// The phase keeps running while enabled; out_en_i only gates the pin, so
// idle gap periods are timed with the same strobes as real SCK periods.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic out_en_i,
  output logic sck_o,
  output logic sck_rise_o,
  output logic sck_fall_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             ph_q, ph_d;
  logic             sck_q, sck_d;
  logic             wrap;

  // Divider/phase next state and edge strobes; disabled means parked at phase 0.
  always_comb begin
    wrap       = en_i && (div_q == DIV_LAST);
    sck_rise_o = wrap & ~ph_q;
    sck_fall_o = wrap & ph_q;
    div_d      = '0;
    ph_d       = 1'b0;
    sck_d      = 1'b0;
    if (en_i) begin
      div_d = wrap ? '0 : div_q + 1'b1;
      ph_d  = wrap ? ~ph_q : ph_q;
      if (sck_rise_o)      sck_d = out_en_i;
      else if (sck_fall_o) sck_d = 1'b0;
      else                 sck_d = sck_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      ph_q  <= 1'b0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ph_q  <= ph_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI master: one op per handshake, serialised as op[1:0] + data[7:0],
// with an 8-bit MISO capture for RD_DATA.
module spi_ram_master
  import spi_ram_master_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int GAP_SCK = 2,
  parameter int RD_LAT  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              seq_err_o,
  output logic              busy_o,
  output logic              sck_o,
  output logic              ss_n_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  localparam int CNT_MAX = max_int(max_int(FRAME_BITS, DATA_W), max_int(RD_LAT, GAP_SCK));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] LAST_CAP  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_SCK - 1);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [DATA_W-1:0]     rx_q, rx_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ss_n_q, ss_n_d;
  logic                  mosi_q, mosi_d;
  logic                  rd_frame_q, rd_frame_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  seq_err_q, seq_err_d;
  logic                  sck_rise, sck_fall, accept;

  assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
  assign busy_o      = (state_q != S_IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Divider runs only while a frame or gap is in progress, so every accept
  // starts from phase 0; the pin is held low through the gap.
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (state_q != S_IDLE),
    .out_en_i   (state_q != S_GAP),
    .sck_o      (sck_o),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall)
  );

  // Frame sequencer: next state plus shift/count/flag updates, all keyed on SCK strobes.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    cnt_d       = cnt_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    rd_frame_d  = rd_frame_q;
    rd_pend_d   = rd_pend_q;
    rsp_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d    = S_LEAD;
        ss_n_d     = 1'b0;
        tx_d       = {cmd_op_i, cmd_data_i};
        mosi_d     = cmd_op_i[1];
        cnt_d      = '0;
        rd_frame_d = (cmd_op_i == OP_RD_DATA);
        if (cmd_op_i == OP_RD_ADDR) rd_pend_d = 1'b1;
        if (cmd_op_i == OP_RD_DATA) begin
          rd_pend_d = 1'b0;
          seq_err_d = ~rd_pend_q;
        end
      end
      // Slave decode period; the fall ending it re-drives bit 0 (op[1]).
      S_LEAD: if (sck_fall) begin
        state_d = S_SHIFT;
        mosi_d  = tx_q[FRAME_BITS-1];
      end
      S_SHIFT: if (sck_fall) begin
        tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
        mosi_d = tx_q[FRAME_BITS-2];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (!rd_frame_q) begin
            state_d = S_GAP;
            ss_n_d  = 1'b1;
          end else if (RD_LAT == 0) begin
            state_d = S_RD_CAP;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: if (sck_fall) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WAIT) begin
          cnt_d   = '0;
          state_d = S_RD_CAP;
        end
      end
      S_RD_CAP: begin
        if (sck_rise) rx_d = {rx_q[DATA_W-2:0], miso_i};
        if (sck_fall) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CAP) begin
            cnt_d       = '0;
            state_d     = S_GAP;
            ss_n_d      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
          end
        end
      end
      S_GAP: if (sck_fall) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_GAP) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rd_frame_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rd_frame_q  <= rd_frame_d;
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rsp_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign ss_n_o      = ss_n_q;
  assign mosi_o      = mosi_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign seq_err_o   = seq_err_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: vector table + frame scoreboard, slave MISO model,
// back-to-back and mid-frame reset sequences.
module tb_spi_ram_master;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic [7:0]  sb;    // byte the slave model returns
    logic [10:0] mosi;  // MOSI at the first 11 rising edges (LEAD + 10 bits)
    int          len;   // SCK periods with ss_n low
    logic        rv;
    logic [7:0]  rsp;
    logic        seq;
  } vec_t;

  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_data = '0, slave_byte = '0;
  logic       miso = 1'b0;
  logic       cmd_ready, rsp_valid, seq_err, busy, sck, ss_n, mosi;
  logic [7:0] rsp_data;

  int   checks = 0, errors = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  spi_ram_master #(.CLK_DIV(2), .GAP_SCK(2), .RD_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data), .seq_err_o(seq_err), .busy_o(busy), .sck_o(sck),
    .ss_n_o(ss_n), .mosi_o(mosi), .miso_i(miso)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] d, input logic [7:0] sb,
                              input logic [10:0] m, input int len, input logic rv,
                              input logic [7:0] rsp, input logic seq);
    vec_t v;
    v.op = op; v.data = d; v.sb = sb; v.mosi = m; v.len = len;
    v.rv = rv; v.rsp = rsp; v.seq = seq;
    return v;
  endfunction

  // Slave model: after falls 12..19 of a frame (RD_LAT=1) drive the reply MSB first.
  int fall_n = 0;
  always @(negedge sck or posedge ss_n) begin
    if (ss_n) begin
      fall_n = 0;
      miso   = 1'b0;
    end else begin
      fall_n++;
      if (fall_n >= 12 && fall_n <= 19) miso = slave_byte[19 - fall_n];
      else                              miso = 1'b0;
    end
  end

  // Frame monitor: samples on negedge, pops the scoreboard when ss_n rises.
  int          cyc = 0, low_cnt = 0, rise_n = 0, rise_cyc = 0, mon_gap = 0;
  logic        ss_prev = 1'b1, sck_prev = 1'b0, seq_seen = 1'b0, gap_chk = 1'b0;
  logic [10:0] bits = '0;
  logic [7:0]  last_rsp = '0;
  vec_t        e;
  always @(negedge clk) begin
    cyc++;
    if (rst) last_rsp = '0;
    if (gap_chk) begin
      gap_chk = 1'b0;
      chk("rsp_pulse_width", rsp_valid, 1'b0);
      chk("ready_in_gap", cmd_ready, 1'b0);
    end
    if (!ss_n && ss_prev) begin
      low_cnt = 0; rise_n = 0; bits = '0; seq_seen = 1'b0;
      mon_gap = cyc - rise_cyc;
    end
    if (!ss_n) begin
      low_cnt++;
      seq_seen = seq_seen | seq_err;
      if (sck && !sck_prev) begin
        if (rise_n < 11) bits = {bits[9:0], mosi};
        rise_n++;
      end
    end
    if (ss_n && !ss_prev) begin
      rise_cyc = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mosi_bits", bits, e.mosi);
        chk("sck_rises", rise_n, e.len);
        chk("ss_low_clk", low_cnt, e.len * 4);
        chk("seq_err", seq_seen, e.seq);
        chk("rsp_valid", rsp_valid, e.rv);
        if (e.rv) begin
          chk("rsp_data", rsp_data, e.rsp);
          last_rsp = e.rsp;
        end else begin
          chk("rsp_held", rsp_data, last_rsp);
        end
        gap_chk = 1'b1;
      end else begin
        chk("abort_no_rsp", rsp_valid, 1'b0);
      end
    end
    ss_prev  = ss_n;
    sck_prev = sck;
  end

  // Drive one command at negedge and hold it until accepted.
  task automatic issue(input vec_t v, input bit push);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data;
    if (push) exp_q.push_back(v);
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b after %0d clk", cmd_ready, n);
    end
    slave_byte = v.sb;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      errors++;
      $display("FAIL frame_timeout: %0d frames outstanding, cmd_ready=%0b", exp_q.size(), cmd_ready);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[10];
    int   n;
    vt[0] = mk(2'b11, 8'h5A, 8'h3C, 11'b111_0101_1010, 20, 1'b1, 8'h3C, 1'b1);
    vt[1] = mk(2'b00, 8'hFF, 8'h00, 11'b000_1111_1111, 11, 1'b0, 8'h00, 1'b0);
    vt[2] = mk(2'b01, 8'h55, 8'h00, 11'b001_0101_0101, 11, 1'b0, 8'h00, 1'b0);
    vt[3] = mk(2'b10, 8'hFF, 8'h00, 11'b110_1111_1111, 11, 1'b0, 8'h00, 1'b0);
    vt[4] = mk(2'b11, 8'h00, 8'hA5, 11'b111_0000_0000, 20, 1'b1, 8'hA5, 1'b0);
    vt[5] = mk(2'b11, 8'hC3, 8'h81, 11'b111_1100_0011, 20, 1'b1, 8'h81, 1'b1);
    vt[6] = mk(2'b10, 8'h12, 8'h00, 11'b110_0001_0010, 11, 1'b0, 8'h00, 1'b0);
    vt[7] = mk(2'b10, 8'h34, 8'h00, 11'b110_0011_0100, 11, 1'b0, 8'h00, 1'b0);
    vt[8] = mk(2'b11, 8'h0F, 8'h7E, 11'b111_0000_1111, 20, 1'b1, 8'h7E, 1'b0);
    vt[9] = mk(2'b01, 8'hA6, 8'h00, 11'b001_1010_0110, 11, 1'b0, 8'h00, 1'b0);

    // Reset held for 3 clk
    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ss_n", ss_n, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_seq_err", seq_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Table of single frames, each run to completion
    for (int i = 0; i < 10; i++) begin
      issue(vt[i], 1'b1);
      wait_frame();
    end

    // Back-to-back: second command held valid while the first is in flight
    issue(mk(2'b01, 8'h55, 8'h00, 11'b001_0101_0101, 11, 1'b0, 8'h00, 1'b0), 1'b1);
    repeat (8) @(negedge clk);
    chk("ready_mid_frame", cmd_ready, 1'b0);
    chk("busy_mid_frame", busy, 1'b1);
    issue(mk(2'b10, 8'h3C, 8'h00, 11'b110_0011_1100, 11, 1'b0, 8'h00, 1'b0), 1'b1);
    wait_frame();
    if (mon_gap < 8 || mon_gap > 12) begin
      errors++;
      $display("FAIL b2b_gap: got %0d clk between ss_n rise and fall, required 8..12", mon_gap);
    end
    checks++;

    // Reset during SHIFT bit 5 (7th rising edge of the frame)
    issue(mk(2'b00, 8'hA5, 8'h00, 11'b000_1010_0101, 11, 1'b0, 8'h00, 1'b0), 1'b0);
    repeat (2) @(negedge clk);
    n = 0;
    while (rise_n < 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rise_n < 7) begin
      errors++;
      $display("FAIL abort_setup: got %0d rising edges, required 7", rise_n);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss_n", ss_n, 1'b1);
    chk("abort_sck", sck, 1'b0);
    chk("abort_mosi", mosi, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_data", rsp_data, 8'h00);
    chk("abort_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", cmd_ready, 1'b1);
    issue(mk(2'b00, 8'h0F, 8'h00, 11'b000_0000_1111, 11, 1'b0, 8'h00, 1'b0), 1'b1);
    wait_frame();
    // RD_ADDR pending before the reset must be forgotten
    issue(mk(2'b11, 8'h00, 8'h99, 11'b111_0000_0000, 20, 1'b1, 8'h99, 1'b1), 1'b1);
    wait_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
